// File: rtl/ifetch_sram_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_sram_bridge_pkg
// Description : Shared types and constants for the instruction-fetch SRAM
//               bridge. It provides the instruction and PC types, the SRAM
//               word-address type, the fetch FSM state encoding and the NOP
//               word.
// Revision    : 1.0 - initial release
// ============================================================================
package ifetch_sram_bridge_pkg;

    // Default SRAM word-address width; modules carry their own SRAM_AW.
    localparam int SRAM_AW_DEF = 20;

    typedef logic [31:0]            Inst_t;
    typedef logic [31:0]            Inst_addr_t;
    typedef logic [SRAM_AW_DEF-1:0] Sram_addr_t;

    typedef enum logic [1:0] {
        IFS_IDLE = 2'd0,
        IFS_REQ  = 2'd1,
        IFS_ERR  = 2'd2
    } Ifetch_state_t;

    localparam Inst_t INST_NOP = 32'h0000_0000;

endpackage : ifetch_sram_bridge_pkg
`default_nettype wire

// File: rtl/ifetch_sram_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_sram_bridge_if
// Description : Instruction SRAM request/acknowledge bus.
//               master modport : bridge side (drives address and request)
//               slave  modport : SRAM side (drives acknowledge and read data)
// Ports       : sram_addr_o [SRAM_AW] word address, sram_req_o request,
//               sram_ack_i acknowledge (data valid same cycle),
//               sram_data_i [32] read data
// Revision    : 1.0 - initial release
// ============================================================================
interface ifetch_sram_bridge_if
    import ifetch_sram_bridge_pkg::*;
#(
    parameter int SRAM_AW = 20
);
    logic [SRAM_AW-1:0] sram_addr_o;
    logic               sram_req_o;
    logic               sram_ack_i;
    Inst_t              sram_data_i;

    modport master (
        output sram_addr_o,
        output sram_req_o,
        input  sram_ack_i,
        input  sram_data_i
    );

    modport slave (
        input  sram_addr_o,
        input  sram_req_o,
        output sram_ack_i,
        output sram_data_i
    );
endinterface : ifetch_sram_bridge_if
`default_nettype wire

// File: rtl/ifetch_line_buf.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_line_buf
// Description : One tagged instruction line: tag/data/valid registers with a
//               fill port, an invalidate strobe and a combinational hit
//               compare against a lookup tag. A fill wins over an invalidate
//               on the same edge.
// Ports       : clk, rst (async, active-low), i_fill_en/i_fill_tag/
//               i_fill_data, i_inval, i_lookup_tag, o_hit, o_data
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_line_buf
    import ifetch_sram_bridge_pkg::*;
#(
    parameter int SRAM_AW = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_fill_en,
    input  logic [SRAM_AW-1:0] i_fill_tag,
    input  Inst_t              i_fill_data,
    input  logic               i_inval,
    input  logic [SRAM_AW-1:0] i_lookup_tag,
    output logic               o_hit,
    output Inst_t              o_data
);
    logic               r_valid;
    logic [SRAM_AW-1:0] r_tag;
    Inst_t              r_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= INST_NOP;
        end else if (i_fill_en) begin
            r_valid <= 1'b1;
            r_tag   <= i_fill_tag;
            r_data  <= i_fill_data;
        end else if (i_inval) begin
            r_valid <= 1'b0;
        end
    end

    assign o_hit  = r_valid && (r_tag == i_lookup_tag);
    assign o_data = r_data;
endmodule : ifetch_line_buf
`default_nettype wire

// File: rtl/ifetch_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_sram_bridge
// Description : Instruction-fetch bridge between the core fetch port and an
//               external instruction SRAM with req/ack handshake. Serves hits
//               from a tagged line buffer, stalls the pipeline on a demand
//               miss, and parks in a sticky error state on ack timeout.
//               Optional macro IFETCH_PREFETCH_EN adds a next-line prefetch
//               entry beside the demand entry.
// Ports       : clk, rst (async, active-low)
//               pc_i, ce_i            fetch PC and enable
//               inst_o, stall_req_o   instruction out, pipeline stall request
//               bus_err_o             sticky ack-timeout flag
//               sram                  SRAM bus (master modport)
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_sram_bridge
    import ifetch_sram_bridge_pkg::*;
#(
    parameter int SRAM_AW     = 20,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  Inst_addr_t                  pc_i,
    input  logic                        ce_i,
    output Inst_t                       inst_o,
    output logic                        stall_req_o,
    output logic                        bus_err_o,
    ifetch_sram_bridge_if.master        sram
);
    // Wait counter only needs to reach ACK_TIMEOUT-1 before the timeout edge.
    localparam int                 c_CNT_W    = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ACK_TIMEOUT - 1);

    Ifetch_state_t      r_state, w_state_nxt;
    logic               r_req;
    logic [SRAM_AW-1:0] r_addr;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_fill_pf;      // outstanding request targets E1

    logic [SRAM_AW-1:0] w_pc_tag;
    logic               w_e0_hit_raw, w_hit0, w_hit1, w_copy;
    Inst_t              w_e0_data;
    logic               w_e0_fill;
    logic [SRAM_AW-1:0] w_e0_fill_tag;
    Inst_t              w_e0_fill_data;
    logic               w_issue, w_issue_pf, w_ack_fill;
    logic [SRAM_AW-1:0] w_issue_addr;
    logic               w_unused;

    assign w_pc_tag = pc_i[SRAM_AW+1:2];
    assign w_unused = ^{pc_i[31:SRAM_AW+2], pc_i[1:0]};
    assign w_hit0   = ce_i && w_e0_hit_raw;
    assign w_e0_fill = (w_ack_fill && !r_fill_pf) || w_copy;

    ifetch_line_buf #(.SRAM_AW(SRAM_AW)) u_e0 (
        .clk          (clk),
        .rst          (rst),
        .i_fill_en    (w_e0_fill),
        .i_fill_tag   (w_e0_fill_tag),
        .i_fill_data  (w_e0_fill_data),
        .i_inval      (1'b0),
        .i_lookup_tag (w_pc_tag),
        .o_hit        (w_e0_hit_raw),
        .o_data       (w_e0_data)
    );

`ifdef IFETCH_PREFETCH_EN
    logic               w_e1_hit_raw, w_pf_have;
    Inst_t              w_e1_data;
    logic [SRAM_AW-1:0] w_e1_lookup;

    // While E0 hits, E1's comparator probes the next line instead, telling
    // whether the prefetch is already in place; a demand hit in E1 only
    // matters when E0 misses, so one comparator serves both questions.
    assign w_e1_lookup = w_hit0 ? (w_pc_tag + SRAM_AW'(1)) : w_pc_tag;
    assign w_pf_have   = w_hit0 && w_e1_hit_raw;
    assign w_hit1      = ce_i && !w_hit0 && w_e1_hit_raw;
    // Promotion happens only in IDLE so it never collides with an SRAM fill.
    assign w_copy      = (r_state == IFS_IDLE) && w_hit1;

    assign w_e0_fill_tag  = w_copy ? w_pc_tag  : r_addr;
    assign w_e0_fill_data = w_copy ? w_e1_data : sram.sram_data_i;

    ifetch_line_buf #(.SRAM_AW(SRAM_AW)) u_e1 (
        .clk          (clk),
        .rst          (rst),
        .i_fill_en    (w_ack_fill && r_fill_pf),
        .i_fill_tag   (r_addr),
        .i_fill_data  (sram.sram_data_i),
        .i_inval      (w_copy || (w_issue && w_issue_pf)),
        .i_lookup_tag (w_e1_lookup),
        .o_hit        (w_e1_hit_raw),
        .o_data       (w_e1_data)
    );
`else
    assign w_hit1         = 1'b0;
    assign w_copy         = 1'b0;
    assign w_e0_fill_tag  = r_addr;
    assign w_e0_fill_data = sram.sram_data_i;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_issue      = 1'b0;
        w_issue_pf   = 1'b0;
        w_issue_addr = w_pc_tag;
        w_ack_fill   = 1'b0;
        case (r_state)
            IFS_IDLE: begin
                if (ce_i && !w_hit0 && !w_hit1) begin
                    w_issue = 1'b1;
                end
`ifdef IFETCH_PREFETCH_EN
                else if (w_hit0 && !w_pf_have) begin
                    w_issue      = 1'b1;
                    w_issue_pf   = 1'b1;
                    w_issue_addr = w_e1_lookup;
                end
`endif
                if (w_issue) begin
                    w_state_nxt = IFS_REQ;
                end
            end
            IFS_REQ: begin
                if (sram.sram_ack_i) begin
                    w_ack_fill  = 1'b1;
                    w_state_nxt = IFS_IDLE;
                end else if ((ACK_TIMEOUT != 0) && (r_cnt == c_CNT_LAST)) begin
                    w_state_nxt = IFS_ERR;
                end
            end
            IFS_ERR: begin
                w_state_nxt = IFS_ERR;
            end
            default: begin
                w_state_nxt = IFS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IFS_IDLE;
            r_req     <= 1'b0;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_fill_pf <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_req     <= 1'b1;
                r_addr    <= w_issue_addr;
                r_cnt     <= '0;
                r_fill_pf <= w_issue_pf;
            end else if (r_state == IFS_REQ) begin
                if (w_state_nxt != IFS_REQ) begin
                    r_req <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end
        end
    end

    // Reset gating keeps stall low while rst is held even though ce_i may be.
    always_comb begin
        inst_o = INST_NOP;
        if (rst && (r_state != IFS_ERR)) begin
            if (w_hit0) begin
                inst_o = w_e0_data;
            end
`ifdef IFETCH_PREFETCH_EN
            else if (w_hit1) begin
                inst_o = w_e1_data;
            end
`endif
        end
    end

    assign stall_req_o      = rst && ce_i && !w_hit0 && !w_hit1 && (r_state != IFS_ERR);
    assign bus_err_o        = (r_state == IFS_ERR);
    assign sram.sram_req_o  = r_req;
    assign sram.sram_addr_o = r_addr;
endmodule : ifetch_sram_bridge
`default_nettype wire

// File: tb/tb_ifetch_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_sram_bridge
// Description : Self-checking bench for ifetch_sram_bridge. An SRAM responder
//               acks after a programmable number of wait states and returns
//               a word derived from the address. A vector table covers the
//               basic hit/miss flow; hand-written sequences cover redirect,
//               reset mid-request, timeout and (with IFETCH_PREFETCH_EN)
//               next-line prefetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_sram_bridge;
    import ifetch_sram_bridge_pkg::*;

    localparam int AW = 20;

    typedef struct {
        logic [31:0] pc;
        logic        ce;
        logic [31:0] inst;
        logic        stall;
        logic        req;
        logic [19:0] addr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_i = 32'h0;
    logic        ce_i = 1'b0;
    logic [31:0] inst_o;
    logic        stall_req_o;
    logic        bus_err_o;

    int n_tests = 0;
    int n_fail  = 0;
    int ws      = 0;
    bit ack_en  = 1'b1;
    int rcnt    = 0;
    int n_req   = 0;

    ifetch_sram_bridge_if #(.SRAM_AW(AW)) sbus ();

    ifetch_sram_bridge #(.SRAM_AW(AW), .ACK_TIMEOUT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_i        (pc_i),
        .ce_i        (ce_i),
        .inst_o      (inst_o),
        .stall_req_o (stall_req_o),
        .bus_err_o   (bus_err_o),
        .sram        (sbus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [19:0] a);
        return {12'hC0D, a};
    endfunction

    // SRAM responder: updates on the falling edge so the DUT sees a stable
    // ack/data at the next rising edge.
    always @(negedge clk) begin
        if (sbus.sram_req_o) begin
            if (rcnt == 0) n_req++;
            sbus.sram_ack_i  = ack_en && (rcnt == ws);
            sbus.sram_data_i = mem(sbus.sram_addr_o);
            rcnt++;
        end else begin
            rcnt             = 0;
            sbus.sram_ack_i  = 1'b0;
            sbus.sram_data_i = 32'hDEAD_BEEF;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic wait_drop(input string name, input int max, output int n);
        n = 0;
        while (sbus.sram_req_o && n < max) begin
            tick();
            n++;
        end
        check(name, 32'(sbus.sram_req_o), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tv[12];
        int   n;
        int   base;

        // ---------------- reset state ----------------
        pc_i = 32'h0; ce_i = 1'b1; rst = 1'b0;
        tick(); tick();
        check("rst_inst",  inst_o, 32'h0);
        check("rst_stall", 32'(stall_req_o), 32'h0);
        check("rst_req",   32'(sbus.sram_req_o), 32'h0);
        check("rst_addr",  32'(sbus.sram_addr_o), 32'h0);
        check("rst_err",   32'(bus_err_o), 32'h0);
        rst = 1'b1;

`ifndef IFETCH_PREFETCH_EN
        // ---------------- table: basic miss/hit flow ----------------
        tv[0]  = '{32'h0000_0000, 1'b1, 32'h0,      1'b1, 1'b0, 20'h0};
        tv[1]  = '{32'h0000_0000, 1'b1, 32'h0,      1'b1, 1'b1, 20'h0};
        tv[2]  = '{32'h0000_0000, 1'b1, mem(20'h0), 1'b0, 1'b0, 20'h0};
        tv[3]  = '{32'h0000_0040, 1'b1, 32'h0,      1'b1, 1'b0, 20'h0};
        tv[4]  = '{32'h0000_0040, 1'b1, 32'h0,      1'b1, 1'b1, 20'h10};
        for (int i = 5; i < 10; i++)
            tv[i] = '{32'h0000_0040, 1'b1, mem(20'h10), 1'b0, 1'b0, 20'h10};
        tv[10] = '{32'h0000_0040, 1'b0, 32'h0,       1'b0, 1'b0, 20'h10};
        tv[11] = '{32'h4000_0043, 1'b1, mem(20'h10), 1'b0, 1'b0, 20'h10};
        ws = 0; ack_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            pc_i = tv[i].pc; ce_i = tv[i].ce;
            #1;
            check($sformatf("v%0d_inst", i),  inst_o, tv[i].inst);
            check($sformatf("v%0d_stall", i), 32'(stall_req_o), 32'(tv[i].stall));
            check($sformatf("v%0d_req", i),   32'(sbus.sram_req_o), 32'(tv[i].req));
            check($sformatf("v%0d_addr", i),  32'(sbus.sram_addr_o), 32'(tv[i].addr));
            tick();
        end
        check("table_nreq", n_req, 2);

        // ---------------- redirect during a 4-wait-state fetch ----------------
        do_reset();
        base = n_req; ws = 4;
        pc_i = 32'h100; ce_i = 1'b1;
        #1 check("rd_stall0", 32'(stall_req_o), 32'h1);
        tick();
        check("rd_req0",  32'(sbus.sram_req_o), 32'h1);
        check("rd_addr0", 32'(sbus.sram_addr_o), 32'h40);
        tick();
        pc_i = 32'h200;
        #1;
        check("rd_req1",   32'(sbus.sram_req_o), 32'h1);
        check("rd_addr1",  32'(sbus.sram_addr_o), 32'h40);
        check("rd_stall1", 32'(stall_req_o), 32'h1);
        wait_drop("rd_drop0", 10, n);
        check("rd_wait0", n, 4);
        check("rd_idle_stall", 32'(stall_req_o), 32'h1);
        pc_i = 32'h100;
        #1;
        check("rd_oldtag_inst",  inst_o, mem(20'h40));
        check("rd_oldtag_stall", 32'(stall_req_o), 32'h0);
        pc_i = 32'h200;
        tick();
        check("rd_req2",  32'(sbus.sram_req_o), 32'h1);
        check("rd_addr2", 32'(sbus.sram_addr_o), 32'h80);
        wait_drop("rd_drop1", 10, n);
        check("rd_wait1", n, 5);
        check("rd_inst",  inst_o, mem(20'h80));
        check("rd_stall", 32'(stall_req_o), 32'h0);
        check("rd_nreq",  n_req - base, 2);

        // ---------------- reset asserted mid-request ----------------
        do_reset();
        ws = 3;
        pc_i = 32'h500; ce_i = 1'b1;
        tick();
        wait_drop("mr_drop0", 10, n);
        check("mr_fill_inst", inst_o, mem(20'h140));
        pc_i = 32'h600;
        tick();
        check("mr_req",  32'(sbus.sram_req_o), 32'h1);
        check("mr_addr", 32'(sbus.sram_addr_o), 32'h180);
        tick();
        rst = 1'b0;
        #1;
        check("mr_rst_req",   32'(sbus.sram_req_o), 32'h0);
        check("mr_rst_stall", 32'(stall_req_o), 32'h0);
        check("mr_rst_inst",  inst_o, 32'h0);
        tick();
        rst = 1'b1;
        #1;
        check("mr_new_stall", 32'(stall_req_o), 32'h1);
        pc_i = 32'h500;
        #1 check("mr_old_stall", 32'(stall_req_o), 32'h1);
        pc_i = 32'h600;
        base = n_req;
        tick();
        check("mr_rereq",  32'(sbus.sram_req_o), 32'h1);
        check("mr_readdr", 32'(sbus.sram_addr_o), 32'h180);
        wait_drop("mr_drop1", 10, n);
        check("mr_inst",  inst_o, mem(20'h180));
        check("mr_nreq",  n_req - base, 1);
`else
        // ---------------- next-line prefetch ----------------
        do_reset();
        base = n_req; ws = 0; ack_en = 1'b1;
        pc_i = 32'h0; ce_i = 1'b1;
        #1 check("pf_stall0", 32'(stall_req_o), 32'h1);
        tick();
        tick();
        check("pf_inst0",  inst_o, mem(20'h0));
        check("pf_stall1", 32'(stall_req_o), 32'h0);
        tick();
        check("pf_req1",   32'(sbus.sram_req_o), 32'h1);
        check("pf_addr1",  32'(sbus.sram_addr_o), 32'h1);
        check("pf_inst1",  inst_o, mem(20'h0));
        tick();
        pc_i = 32'h4;
        #1;
        check("pf_hit4_stall", 32'(stall_req_o), 32'h0);
        check("pf_hit4_inst",  inst_o, mem(20'h1));
        tick();
        check("pf_copy_req", 32'(sbus.sram_req_o), 32'h0);
        tick();
        check("pf_req2",  32'(sbus.sram_req_o), 32'h1);
        check("pf_addr2", 32'(sbus.sram_addr_o), 32'h2);
        pc_i = 32'h8;
        #1 check("pf_wait_stall", 32'(stall_req_o), 32'h1);
        tick();
        check("pf_hit8_stall", 32'(stall_req_o), 32'h0);
        check("pf_hit8_inst",  inst_o, mem(20'h2));
        tick();
        tick();
        check("pf_req3",  32'(sbus.sram_req_o), 32'h1);
        check("pf_addr3", 32'(sbus.sram_addr_o), 32'h3);
        check("pf_nreq",  n_req - base, 4);
`endif

        // ---------------- ack timeout ----------------
        do_reset();
        ws = 0; ack_en = 1'b1;
        pc_i = 32'h0; ce_i = 1'b1;
        tick();
        tick();
        check("to_fill", inst_o, mem(20'h0));
        ack_en = 1'b0;
        pc_i = 32'h300;
        #1 check("to_stall0", 32'(stall_req_o), 32'h1);
        tick();
        repeat (7) tick();
        check("to_req_last", 32'(sbus.sram_req_o), 32'h1);
        check("to_err_pre",  32'(bus_err_o), 32'h0);
        tick();
        check("to_err",   32'(bus_err_o), 32'h1);
        check("to_req",   32'(sbus.sram_req_o), 32'h0);
        check("to_stall", 32'(stall_req_o), 32'h0);
        ack_en = 1'b1;
        pc_i = 32'h0;
        #1;
        check("to_inst_nop", inst_o, 32'h0);
        check("to_hit_stall", 32'(stall_req_o), 32'h0);
        repeat (3) tick();
        check("to_sticky", 32'(bus_err_o), 32'h1);
        check("to_noreq",  32'(sbus.sram_req_o), 32'h0);
        rst = 1'b0;
        #1 check("to_clear", 32'(bus_err_o), 32'h0);
        tick();
        rst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule : tb_ifetch_sram_bridge
`default_nettype wire

// File: doc/ifetch_sram_bridge.md
Name: ifetch_sram_bridge

Overview:
- Instruction-fetch bridge between the core's fetch port (PC, chip-enable in; instruction out) and an external instruction SRAM with a req/ack handshake and variable wait states.
- Holds the most recently fetched word in a tagged line buffer and serves repeated or stalled PCs from it.
- Raises a stall request to the pipeline controller while a demand fetch is outstanding.

Parameters:
- SRAM_AW, 20, SRAM word-address width; SRAM address is pc_i[SRAM_AW+1:2].
- ACK_TIMEOUT, 255, max cycles waiting for sram_ack_i before the bus-error flag is set; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- pc_i  in  32  fetch PC from pc register
- ce_i  in  1  fetch enable from pc register
- inst_o  out  32  instruction word to if/id register
- stall_req_o  out  1  high while pc_i is enabled but its word is not available
- sram_addr_o  out  SRAM_AW  SRAM word address
- sram_req_o  out  1  request; held until acknowledged
- sram_ack_i  in  1  SRAM acknowledge; data is valid in the same cycle
- sram_data_i  in  32  SRAM read data
- bus_err_o  out  1  sticky timeout flag; cleared only by reset

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state IDLE; all buffer valid bits 0
  - sram_req_o=0, sram_addr_o=0, bus_err_o=0, timeout counter 0
  - inst_o=0 and stall_req_o=0 while in reset
- Reset asserted mid-transaction abandons the request: req drops immediately and no data is captured.
- Hit: ce_i=1 and a valid entry's tag equals pc_i[SRAM_AW+1:2].
  - inst_o is the entry data and stall_req_o=0, both combinational in the same cycle.
  - pc_i[1:0] and bits above SRAM_AW+1 are ignored.
- ce_i=0: inst_o=0, stall_req_o=0, and no new request is issued. An outstanding request still completes and fills its entry.
- Demand miss (ce_i=1, no hit): stall_req_o=1 combinationally.
- FSM states: IDLE, REQ, ERR.
  - IDLE -> REQ on a clock edge with a demand miss. sram_req_o=1 and sram_addr_o=miss address are registered, so they are visible the next cycle.
  - REQ: sram_addr_o is held stable. The clock edge where sram_ack_i=1 captures sram_data_i into the entry, sets valid, drops sram_req_o, and returns to IDLE.
  - Minimum miss penalty is 2 cycles (ack in the first REQ cycle). Each wait state adds 1 cycle.
  - REQ -> ERR when the counter reaches ACK_TIMEOUT. In ERR: bus_err_o=1, req=0, inst_o=32'h0000_0000 (NOP), stall_req_o=0. ERR is exited only by reset.
- PC change while in REQ (branch redirect): the request is not aborted.
  - The word is captured under its original tag.
  - The next cycle re-evaluates hit/miss against the new pc_i.
- A request is never issued in the same cycle as an ack. Back-to-back misses therefore have one IDLE cycle between them.
- The SRAM address wraps naturally at 2^SRAM_AW.

Optional Feature:
- Macro: IFETCH_PREFETCH_EN.
- Defined:
  - A second entry E1 (prefetch) is added beside the demand entry E0.
  - In IDLE with no demand miss and E1 not holding E0.tag+1, the block issues a request for E0.tag+1 (wrapping) into E1.
  - A demand miss has priority at issue time.
  - A demand miss arriving during an outstanding prefetch waits for it to complete. If the prefetched tag matches, the miss becomes a hit with no extra request.
  - A hit in E1 copies E1 into E0 and invalidates E1 on that edge, which triggers the next prefetch.
- Undefined: single entry only; the SRAM is idle except on demand misses.

Decomposition:
- Add to cpu_defines.svh:
  - Sram_addr_t (logic [SRAM_AW-1:0])
  - Ifetch_state_t enum {IFS_IDLE, IFS_REQ, IFS_ERR}
  - constant INST_NOP = 32'h0
- Reuse the existing Inst_t and Inst_addr_t.
- One sub-module, ifetch_line_buf: tag/data/valid register with fill port, invalidate, and combinational hit compare. It is instantiated once, or twice with IFETCH_PREFETCH_EN.

Test Plan:
- Reset, then pc_i=0x0000_0000, ce_i=1; SRAM acks 1 cycle after req:
  - stall high 2 cycles; sram_addr_o=0
  - inst_o=SRAM word, stall low on cycle 3
- Hold pc_i=0x0000_0040 for 5 cycles after fill -> exactly one request (addr 0x10); inst_o stable; stall=0 after fill.
- Redirect pc_i from 0x100 to 0x200 during a 4-wait-state fetch:
  - 0x100 request completes (addr 0x40)
  - one IDLE cycle, then req at addr 0x80
  - correct word for 0x200
- Never ack, ACK_TIMEOUT=8 -> bus_err_o=1 after 8 REQ cycles; req=0; inst_o=0; stall=0; only rst=0 clears the flag.
- Assert rst=0 mid-REQ -> sram_req_o=0 immediately; after release, the same pc re-requests and the old data is not used.
- IFETCH_PREFETCH_EN, sequential pc 0x0,0x4,0x8 with 0-wait ack:
  - prefetch for addr 1 issued while pc=0x0
  - pc=0x4 hits with no stall
  - a prefetch of addr 3 follows
